// File: rtl/als_sampler.sv
// PmodALS (ADC081S021) acquisition controller: periodic SPI read frames, frame
// format check, and a block average over 2^AVG_LOG2 good samples.
module als_sampler #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 10_000_000,
    parameter int AVG_LOG2      = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       miso_i,
    output logic       ss_o,
    output logic       sclk_o,
    output logic [7:0] raw_o,
    output logic [7:0] data_o,
    output logic       raw_stb_o,
    output logic       avg_stb_o,
    output logic       fmt_err_o,
    output logic       busy_o
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int TMR_W = $clog2(SAMPLE_PERIOD);
    localparam int ACC_W = 8 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SAMPLE_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << AVG_LOG2);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        CHECK
    } state_e;

    state_e           state_q;
    logic [DIV_W-1:0] divCnt_q;
    logic [3:0]       bitCnt_q;
    logic [15:0]      sh_q;
    logic [1:0]       sync_q;
    logic [TMR_W-1:0] timer_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       raw_q;
    logic [7:0]       data_q;
    logic             rawStb_q;
    logic             avgStb_q;
    logic             fmtErr_q;
    logic             ss_q;
    logic             sclk_q;

    logic             misoSync;
    logic             divLast;
    logic             frameGood_d;
    logic [7:0]       sample_d;
    logic [ACC_W-1:0] accSum_d;
    logic [CNT_W-1:0] cntNext_d;

    assign misoSync    = sync_q[1];
    assign divLast     = (divCnt_q == DIV_LAST);
    assign sample_d    = sh_q[12:5];
    assign frameGood_d = (sh_q[15:13] == 3'b000) && (sh_q[4:1] == 4'b0000);
    assign accSum_d    = acc_q + ACC_W'(sample_d);
    assign cntNext_d   = cnt_q + CNT_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], miso_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            divCnt_q <= '0;
            bitCnt_q <= '0;
            sh_q     <= '0;
            timer_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            raw_q    <= '0;
            data_q   <= '0;
            rawStb_q <= 1'b0;
            avgStb_q <= 1'b0;
            fmtErr_q <= 1'b0;
            ss_q     <= 1'b1;
            sclk_q   <= 1'b1;
        end else begin
            rawStb_q <= 1'b0;
            avgStb_q <= 1'b0;
            fmtErr_q <= 1'b0;

            // Period timer is reloaded on each frame start and parked at zero while disabled.
            if (!en_i) begin
                timer_q <= '0;
            end else if (state_q == IDLE && timer_q == '0) begin
                timer_q <= TMR_LOAD;
            end else if (timer_q != '0) begin
                timer_q <= timer_q - 1'b1;
            end

            case (state_q)
                IDLE: begin
                    ss_q   <= 1'b1;
                    sclk_q <= 1'b1;
                    if (!en_i) begin
                        acc_q <= '0;
                        cnt_q <= '0;
                    end else if (timer_q == '0) begin
                        state_q  <= SETUP;
                        ss_q     <= 1'b0;
                        divCnt_q <= '0;
                    end
                end
                SETUP: begin
                    if (divLast) begin
                        state_q  <= SHIFT;
                        divCnt_q <= '0;
                        bitCnt_q <= '0;
                        sclk_q   <= 1'b0;
                    end else begin
                        divCnt_q <= divCnt_q + 1'b1;
                    end
                end
                SHIFT: begin
                    // Each period is a low half then a high half; sampling is on the rising edge.
                    if (divLast) begin
                        divCnt_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            sh_q   <= {sh_q[14:0], misoSync};
                        end else if (bitCnt_q == 4'd15) begin
                            state_q <= HOLD;
                        end else begin
                            sclk_q   <= 1'b0;
                            bitCnt_q <= bitCnt_q + 1'b1;
                        end
                    end else begin
                        divCnt_q <= divCnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (divLast) begin
                        divCnt_q <= '0;
                        state_q  <= CHECK;
                        ss_q     <= 1'b1;
                        if (frameGood_d) begin
                            raw_q    <= sample_d;
                            rawStb_q <= 1'b1;
                            if (cntNext_d == CNT_FULL) begin
                                data_q   <= accSum_d[ACC_W-1:AVG_LOG2];
                                avgStb_q <= 1'b1;
                                acc_q    <= '0;
                                cnt_q    <= '0;
                            end else begin
                                acc_q <= accSum_d;
                                cnt_q <= cntNext_d;
                            end
                        end else begin
                            fmtErr_q <= 1'b1;
                        end
                    end else begin
                        divCnt_q <= divCnt_q + 1'b1;
                    end
                end
                CHECK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ss_o      = ss_q;
    assign sclk_o    = sclk_q;
    assign busy_o    = ~ss_q;
    assign raw_o     = raw_q;
    assign data_o    = data_q;
    assign raw_stb_o = rawStb_q;
    assign avg_stb_o = avgStb_q;
    assign fmt_err_o = fmtErr_q;

endmodule
